// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART/ALU sequencing controller.
// States, opcode values and default widths.
package uart_alu_pkg;

  localparam int DBIT_DEF = 8;
  localparam int OPW_DEF  = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Clearable saturating idle counter with an expiry flag.
// Used by uart_alu_ctrl only when UART_ALU_CTRL_TIMEOUT_EN is defined.
module frame_timeout_cnt #(
  parameter int TOUT_CYC = 50000000,
  parameter int TOUT_BIT = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TOUT_BIT-1:0] MAX =
    TOUT_BIT'(TOUT_CYC - 1);

  logic [TOUT_BIT-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == MAX);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frames A, B, opcode from UART RX, drives the ALU, sends the result.
// Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int OPW      = OPW_DEF,
  parameter int TOUT_CYC = 50000000,
  parameter int TOUT_BIT = 26
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            done_tick,
  output logic            err_tick,
  output logic [2:0]      state_dbg
);

  if (TOUT_BIT < $clog2(TOUT_CYC)) begin : g_bad_tout
    $error("TOUT_BIT cannot hold TOUT_CYC");
  end

  state_t state;
  logic   rx_ok;
  logic   tout;

  // The RX flag lags rd_uart by one edge; skip that cycle.
  assign rx_ok = !rx_empty && !rd_uart;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic tout_en;
  logic tout_hit;

  assign tout_en = (state == ST_WAIT_B) ||
                   (state == ST_WAIT_OP);

  frame_timeout_cnt #(
    .TOUT_CYC (TOUT_CYC),
    .TOUT_BIT (TOUT_BIT)
  ) u_tout (
    .clk     (clk),
    .reset   (reset),
    .clr     (rd_uart || !tout_en),
    .en      (tout_en),
    .expired (tout_hit)
  );

  assign tout = tout_hit && rx_empty && !rd_uart;
`else
  assign tout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_WAIT_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      w_data    <= '0;
      rd_uart   <= 1'b0;
      wr_uart   <= 1'b0;
      done_tick <= 1'b0;
      err_tick  <= 1'b0;
    end else begin
      rd_uart   <= 1'b0;
      wr_uart   <= 1'b0;
      done_tick <= 1'b0;
      err_tick  <= 1'b0;
      case (state)
        ST_WAIT_A: begin
          if (rx_ok) begin
            alu_a   <= r_data;
            rd_uart <= 1'b1;
            state   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (rx_ok) begin
            alu_b   <= r_data;
            rd_uart <= 1'b1;
            state   <= ST_WAIT_OP;
          end else if (tout) begin
            err_tick <= 1'b1;
            state    <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          if (rx_ok) begin
            alu_op  <= r_data[OPW-1:0];
            rd_uart <= 1'b1;
            state   <= ST_EXEC;
          end else if (tout) begin
            err_tick <= 1'b1;
            state    <= ST_WAIT_A;
          end
        end
        ST_EXEC: begin
          w_data <= alu_result;
          state  <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_full) begin
            wr_uart   <= 1'b1;
            done_tick <= 1'b1;
            state     <= ST_WAIT_A;
          end
        end
        default: state <= ST_WAIT_A;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small ALU and RX/TX models.
// Timeout checks follow UART_ALU_CTRL_TIMEOUT_EN.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       done_tick;
  logic       err_tick;
  logic [2:0] state_dbg;

  int vectors = 0;
  int errs    = 0;
  int rd_cnt  = 0;
  logic [7:0] wr_q[$];

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .DBIT     (8),
    .OPW      (6),
    .TOUT_CYC (100),
    .TOUT_BIT (26)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .done_tick  (done_tick),
    .err_tick   (err_tick),
    .state_dbg  (state_dbg)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (rd_uart) rd_cnt <= rd_cnt + 1;
    if (wr_uart) wr_q.push_back(w_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int budget);
    bit seen = 1'b0;
    @(negedge clk);
    r_data   = b;
    rx_empty = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rd_uart) seen = 1'b1;
    end
    chk("rd_handshake", 32'(seen), 32'd1);
    if (seen) @(posedge clk);
    #1 rx_empty = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rd0;
    int wq0;
    int bad;
    int err_at;

    reset    = 1'b0;
    rx_empty = 1'b1;
    tx_full  = 1'b0;
    r_data   = 8'h00;
    step(3);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_a", 32'(alu_a), 32'h0);
    chk("rst_wdata", 32'(w_data), 32'h0);
    chk("rst_pulses",
        {28'd0, rd_uart, wr_uart, done_tick, err_tick},
        32'd0);
    reset = 1'b1;

    // basic add 05 + 03
    rd0 = rd_cnt;
    wq0 = wr_q.size();
    send_byte(8'h05, 20);
    chk("add_a_state", 32'(state_dbg), 32'd1);
    chk("add_a_val", 32'(alu_a), 32'h05);
    send_byte(8'h03, 20);
    chk("add_b_state", 32'(state_dbg), 32'd2);
    chk("add_b_keep_a", 32'(alu_a), 32'h05);
    chk("add_b_val", 32'(alu_b), 32'h03);
    send_byte(8'h20, 20);
    step(1);
    chk("add_send", 32'(state_dbg), 32'd4);
    chk("add_wdata", 32'(w_data), 32'h08);
    chk("add_no_wr_early", 32'(wr_uart), 32'd0);
    step(1);
    chk("add_wr", 32'(wr_uart), 32'd1);
    chk("add_done", 32'(done_tick), 32'd1);
    step(1);
    chk("add_wr_1cyc", 32'(wr_uart), 32'd0);
    chk("add_idle", 32'(state_dbg), 32'd0);
    chk("add_rd_cnt", 32'(rd_cnt - rd0), 32'd3);
    chk("add_wr_cnt", 32'(wr_q.size() - wq0), 32'd1);

    // TX backpressure, F0 | 0F
    tx_full = 1'b1;
    send_byte(8'hF0, 20);
    send_byte(8'h0F, 20);
    send_byte(8'h25, 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (state_dbg !== 3'd4 || wr_uart !== 1'b0 ||
          w_data !== 8'hFF) bad++;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    tx_full = 1'b0;
    step(1);
    chk("bp_wr", 32'(wr_uart), 32'd1);
    chk("bp_wdata", 32'(w_data), 32'hFF);
    chk("bp_done", 32'(done_tick), 32'd1);
    step(1);

    // reset mid-frame
    wq0 = wr_q.size();
    send_byte(8'h11, 20);
    send_byte(8'h22, 20);
    chk("mid_state", 32'(state_dbg), 32'd2);
    step(1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    chk("mid_rst_b", 32'(alu_b), 32'h0);
    send_byte(8'h01, 20);
    send_byte(8'h01, 20);
    send_byte(8'h22, 20);
    step(3);
    chk("mid_wr_cnt", 32'(wr_q.size() - wq0), 32'd1);
    chk("mid_result", 32'(wr_q[$]), 32'h00);
    chk("mid_a", 32'(alu_a), 32'h01);

    // back-to-back frames while TX busy
    rd0 = rd_cnt;
    wq0 = wr_q.size();
    tx_full = 1'b1;
    fork
      begin
        send_byte(8'h10, 40);
        send_byte(8'h20, 40);
        send_byte(8'h20, 40);
        send_byte(8'h09, 40);
        send_byte(8'h04, 40);
        send_byte(8'h22, 40);
      end
      begin
        step(15);
        tx_full = 1'b0;
        for (int i = 0; i < 60; i++) begin
          step(1);
          if (wr_uart) begin
            tx_full = 1'b1;
            step(8);
            tx_full = 1'b0;
          end
        end
      end
    join
    chk("b2b_rd_cnt", 32'(rd_cnt - rd0), 32'd6);
    chk("b2b_wr_cnt", 32'(wr_q.size() - wq0), 32'd2);
    if (wr_q.size() >= wq0 + 2) begin
      chk("b2b_first", 32'(wr_q[wq0]), 32'h30);
      chk("b2b_second", 32'(wr_q[wq0+1]), 32'h05);
    end

    // inter-byte idle after operand A
    tx_full = 1'b0;
    step(2);
    wq0 = wr_q.size();
    send_byte(8'hAA, 20);
    err_at = 0;
    for (int k = 1; k <= 110; k++) begin
      step(1);
      if (err_tick && err_at == 0) err_at = k;
    end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    chk("tout_err_at", 32'(err_at), 32'd101);
    chk("tout_state", 32'(state_dbg), 32'd0);
    send_byte(8'h07, 20);
    send_byte(8'h02, 20);
    send_byte(8'h20, 20);
    step(3);
    chk("tout_next_wr", 32'(wr_q.size() - wq0), 32'd1);
    chk("tout_next_res", 32'(wr_q[$]), 32'h09);
`else
    chk("idle_no_err", 32'(err_at), 32'd0);
    chk("idle_state", 32'(state_dbg), 32'd1);
    send_byte(8'h02, 20);
    send_byte(8'h20, 20);
    step(3);
    chk("idle_wr", 32'(wr_q.size() - wq0), 32'd1);
    chk("idle_res", 32'(wr_q[$]), 32'hAC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
